// File: rtl/mdr_ctrl_pkg.sv
// Shared types and defaults for the MDR byte sequencer and the CPU control unit.
package mdr_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    CAP  = 3'd2,
    SHF  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } mdr_state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam int DEF_BYTES_PER_WORD = 2;
  localparam int DEF_ADDR_W         = 12;
  localparam int DEF_WAIT_MAX       = 15;

endpackage

// File: rtl/mdr_seq_ctrl_if.sv
// Requester, memory and MDR strobe signals of the byte sequencer.
interface mdr_seq_ctrl_if #(
  parameter int ADDR_W = mdr_ctrl_pkg::DEF_ADDR_W
);
  logic              req;
  logic              rw;
  logic [ADDR_W-1:0] base_addr;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic              mem_wr;
  logic              mem_rdy;
  logic              mdr_re;
  logic              mdr_we;
  logic              mdr_shift;

  // master: requester plus memory ready; slave: the sequencer itself
  modport master (
    output req, rw, base_addr, mem_rdy,
    input  busy, done, err, mem_addr, mem_en, mem_wr, mdr_re, mdr_we, mdr_shift
  );

  modport slave (
    input  req, rw, base_addr, mem_rdy,
    output busy, done, err, mem_addr, mem_en, mem_wr, mdr_re, mdr_we, mdr_shift
  );
endinterface

// File: rtl/mdr_wait_timer.sv
// Per-byte wait-state budget: down-counter loaded with WAIT_MAX, flags the last allowed stall.
module mdr_wait_timer #(
  parameter int WAIT_MAX = mdr_ctrl_pkg::DEF_WAIT_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= CW'(WAIT_MAX);
    end else if (clr) begin
      cnt <= CW'(WAIT_MAX);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  // terminal count: this stall is the WAIT_MAX-th one; zero budget never expires
  assign expired = (WAIT_MAX != 0) && (cnt == CW'(1));

endmodule

// File: rtl/mdr_seq_ctrl.sv
// Moves one BYTES_PER_WORD-byte word between byte-wide memory and the MDR.
//
// state | meaning
// IDLE  | waiting for req; outputs low, mem_addr 0
// REQ   | memory cycle for byte k, waiting on mem_rdy
// CAP   | read only: MDR captures byte k
// SHF   | MDR shifts one byte, k advances
// DONE  | one-cycle completion pulse
// ERR   | one-cycle wait-timeout abort pulse
module mdr_seq_ctrl
  import mdr_ctrl_pkg::*;
#(
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int WAIT_MAX       = DEF_WAIT_MAX
) (
  input logic           clk,
  input logic           rst,
  mdr_seq_ctrl_if.slave bus
);
  localparam int KW = (BYTES_PER_WORD < 2) ? 1 : $clog2(BYTES_PER_WORD);

  mdr_state_t        state;
  logic [KW-1:0]     k;
  logic              rw_q;
  logic [ADDR_W-1:0] base_q;

  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_en_q;
  logic              mem_wr_q;
  logic              mdr_re_q;
  logic              mdr_we_q;
  logic              mdr_shift_q;

  logic tmr_clr;
  logic tmr_en;
  logic tmr_expired;
  logic last_byte;

  assign last_byte = (k == KW'(BYTES_PER_WORD - 1));
  assign tmr_clr   = ((state == IDLE) && bus.req) || (state == SHF);
  assign tmr_en    = (state == REQ) && !bus.mem_rdy;

  mdr_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  // outputs are registered together with the state they decode
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      rw_q        <= RW_READ;
      base_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mdr_re_q    <= 1'b0;
      mdr_we_q    <= 1'b0;
      mdr_shift_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mdr_re_q    <= 1'b0;
      mdr_shift_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req) begin
            state      <= REQ;
            rw_q       <= bus.rw;
            base_q     <= bus.base_addr;
            k          <= '0;
            busy_q     <= 1'b1;
            mem_addr_q <= bus.base_addr;
            mem_en_q   <= 1'b1;
            mem_wr_q   <= bus.rw;
            mdr_we_q   <= bus.rw;
          end
        end
        REQ: begin
          if (bus.mem_rdy) begin
            mem_en_q <= 1'b0;
            mem_wr_q <= 1'b0;
            mdr_we_q <= 1'b0;
            if (rw_q == RW_READ) begin
              state    <= CAP;
              mdr_re_q <= 1'b1;
            end else if (last_byte) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state       <= SHF;
              mdr_shift_q <= 1'b1;
            end
          end else if (tmr_expired) begin
            state    <= ERR;
            err_q    <= 1'b1;
            mem_en_q <= 1'b0;
            mem_wr_q <= 1'b0;
            mdr_we_q <= 1'b0;
          end
        end
        CAP: begin
          if (last_byte) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            state       <= SHF;
            mdr_shift_q <= 1'b1;
          end
        end
        SHF: begin
          state      <= REQ;
          k          <= k + KW'(1);
          mem_addr_q <= base_q + ADDR_W'(k) + ADDR_W'(1);
          mem_en_q   <= 1'b1;
          mem_wr_q   <= rw_q;
          mdr_we_q   <= rw_q;
        end
        DONE, ERR: begin
          state      <= IDLE;
          busy_q     <= 1'b0;
          mem_addr_q <= '0;
        end
        default: begin
          state      <= IDLE;
          busy_q     <= 1'b0;
          mem_addr_q <= '0;
          mem_en_q   <= 1'b0;
          mem_wr_q   <= 1'b0;
          mdr_we_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mdr_re    = mdr_re_q;
  assign bus.mdr_we    = mdr_we_q;
  assign bus.mdr_shift = mdr_shift_q;

endmodule

// File: tb/tb_mdr_seq_ctrl.sv
// Cycle-accurate bench: expected output trace per transaction is built from per-byte wait counts.
module tb_mdr_seq_ctrl;
  import mdr_ctrl_pkg::*;

  localparam int N  = 2;
  localparam int AW = 12;
  localparam int WM = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mdr_seq_ctrl_if #(.ADDR_W(AW)) bus ();

  mdr_seq_ctrl #(
    .BYTES_PER_WORD (N),
    .ADDR_W         (AW),
    .WAIT_MAX       (WM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  bit          rdy_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {busy,done,err,mem_en,mem_wr,mdr_re,mdr_we,mdr_shift} above the address
  function automatic logic [31:0] pack(input bit b, input bit d, input bit e, input bit en,
                                       input bit wr, input bit re, input bit we, input bit sh,
                                       input logic [AW-1:0] a);
    return {12'h0, b, d, e, en, wr, re, we, sh, a};
  endfunction

  function automatic logic [31:0] dut_vec();
    return pack(bus.busy, bus.done, bus.err, bus.mem_en, bus.mem_wr,
                bus.mdr_re, bus.mdr_we, bus.mdr_shift, bus.mem_addr);
  endfunction

  // Cycle 0 is the accepting IDLE cycle; mem_rdy outside REQ is random and must be ignored.
  task automatic build(input bit rw, input logic [AW-1:0] base, input int waits[N]);
    logic [AW-1:0] a;
    exp_q.delete();
    rdy_q.delete();
    exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 0, 0, '0));
    rdy_q.push_back(1'($urandom));
    for (int j = 0; j < N; j++) begin
      a = base + j[AW-1:0];
      if (WM != 0 && waits[j] >= WM) begin
        repeat (WM) begin
          exp_q.push_back(pack(1, 0, 0, 1, rw, 0, rw, 0, a));
          rdy_q.push_back(1'b0);
        end
        exp_q.push_back(pack(1, 0, 1, 0, 0, 0, 0, 0, a));
        rdy_q.push_back(1'($urandom));
        return;
      end
      for (int w = 0; w <= waits[j]; w++) begin
        exp_q.push_back(pack(1, 0, 0, 1, rw, 0, rw, 0, a));
        rdy_q.push_back(w == waits[j]);
      end
      if (rw == RW_READ) begin
        exp_q.push_back(pack(1, 0, 0, 0, 0, 1, 0, 0, a));
        rdy_q.push_back(1'($urandom));
      end
      if (j < N - 1) begin
        exp_q.push_back(pack(1, 0, 0, 0, 0, 0, 0, 1, a));
        rdy_q.push_back(1'($urandom));
      end
    end
    exp_q.push_back(pack(1, 1, 0, 0, 0, 0, 0, 0, base + AW'(N - 1)));
    rdy_q.push_back(1'($urandom));
  endtask

  // req_mode: 0 = low while busy, 1 = random noise while busy, 2 = held high
  task automatic run(input string name, input bit rw, input logic [AW-1:0] base,
                     input int waits[N], input int abort_at, input int req_mode);
    build(rw, base, waits);
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk);
      check_val($sformatf("%s c%0d", name, c), dut_vec(), exp_q[c]);
      bus.mem_rdy = rdy_q[c];
      if (c == 0) begin
        bus.req       = 1'b1;
        bus.rw        = rw;
        bus.base_addr = base;
      end else begin
        bus.req       = (req_mode == 2) ? 1'b1 : (req_mode == 1) ? 1'($urandom) : 1'b0;
        bus.rw        = 1'($urandom);
        bus.base_addr = AW'($urandom);
      end
      if (c == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check_val($sformatf("%s rst", name), dut_vec(), pack(0, 0, 0, 0, 0, 0, 0, 0, '0));
        rst     = 1'b0;
        bus.req = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w[N];
    bus.req       = 1'b0;
    bus.rw        = RW_READ;
    bus.base_addr = '0;
    bus.mem_rdy   = 1'b0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset", dut_vec(), pack(0, 0, 0, 0, 0, 0, 0, 0, '0));
    rst = 1'b0;

    w = '{0, 0};   run("rd_0fe",  RW_READ,  12'h0FE, w, -1, 0);
    w = '{2, 2};   run("wr_010",  RW_WRITE, 12'h010, w, -1, 0);
    w = '{0, 0};   run("rd_wrap", RW_READ,  12'hFFF, w, -1, 0);
    w = '{20, 0};  run("tmo",     RW_READ,  12'h123, w, -1, 0);
    w = '{1, 0};   run("post_tmo", RW_READ, 12'h200, w, -1, 0);
    w = '{14, 14}; run("max_wait", RW_WRITE, 12'h300, w, -1, 0);
    w = '{0, 20};  run("tmo_b1",  RW_WRITE, 12'h0A0, w, -1, 1);
    w = '{0, 0};   run("busy_req", RW_READ, 12'h055, w, -1, 1);
    w = '{0, 0};   run("b2b_a",   RW_READ,  12'h400, w, -1, 2);
    w = '{0, 0};   run("b2b_b",   RW_READ,  12'h500, w, -1, 0);
    w = '{0, 0};   run("rst_cap", RW_READ,  12'h600, w, 2, 0);
    w = '{0, 0};   run("post_rst", RW_READ, 12'h700, w, -1, 0);

    for (int t = 0; t < 60; t++) begin
      int r;
      int ab;
      for (int j = 0; j < N; j++) begin
        r = int'($urandom_range(0, 19));
        w[j] = (r < 15) ? (r % 4) : (r == 15) ? 14 : r;
      end
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : -1;
      run($sformatf("rnd%0d", t), 1'($urandom), AW'($urandom), w, ab, int'($urandom_range(0, 1)));
    end

    @(negedge clk);
    bus.req = 1'b0;
    check_val("final_idle", dut_vec(), pack(0, 0, 0, 0, 0, 0, 0, 0, '0));
    @(negedge clk);
    check_val("stay_idle", dut_vec(), pack(0, 0, 0, 0, 0, 0, 0, 0, '0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mdr_seq_ctrl.md
Name: mdr_seq_ctrl

Overview:
Sequencer that moves one multi-byte word between byte-wide memory and the MDR.
- On a single request it issues memory cycles with incrementing byte addresses and handles memory wait states.
- It drives the MDR's re, we and shift strobes so the word is assembled on reads and serialised on writes.
- It sits between the CPU control unit (requester) and the memory/MDR datapath.
- A wait-state timeout aborts the transaction if memory stalls.

Parameters:
- BYTES_PER_WORD, default 2: bytes per transaction (N); legal range 1 to 8.
- ADDR_W, default 12: memory byte-address width.
- WAIT_MAX, default 15: maximum consecutive not-ready cycles per byte; 0 disables the timeout.

Ports:
- clk, input, 1: system clock; rising-edge only.
- rst, input, 1: synchronous reset, active-high.
- req, input, 1: start a transaction; sampled only in IDLE.
- rw, input, 1: 0 = read (memory to MDR), 1 = write (MDR to memory); latched at accept.
- base_addr, input, ADDR_W: address of byte 0; latched at accept.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse on successful completion.
- err, output, 1: one-cycle pulse on timeout abort.
- mem_addr, output, ADDR_W: current byte address.
- mem_en, output, 1: memory cycle request.
- mem_wr, output, 1: write qualifier, valid with mem_en.
- mem_rdy, input, 1: memory completes the current byte this cycle.
- mdr_re, output, 1: MDR loads the memory byte on in1.
- mdr_we, output, 1: MDR drives its byte to memory.
- mdr_shift, output, 1: MDR shifts by one byte.

Behaviour:
- Reset: the next edge after rst=1 forces IDLE, clears the byte index and wait counter, and drops all outputs to 0.
  - Applies mid-transaction: no done or err is produced for the aborted transfer, and rst has priority over everything.
- States: IDLE, REQ, CAP, SHF, DONE, ERR.
  - All outputs are Moore decodes of the state and registered latches.
  - mem_addr = latched base + byte index k, modulo 2^ADDR_W (wraps 0xFFF to 0x000 for ADDR_W=12). It is 0 in IDLE.
- IDLE: if req=1, latch rw and base_addr, set k=0 and wait=0, go to REQ. Otherwise stay.
- REQ:
  - Outputs: mem_en=1, mem_wr=rw, mdr_we=rw.
  - mem_rdy=1:
    - Read: go to CAP.
    - Write: go to DONE if k=N-1, else go to SHF.
  - mem_rdy=0: wait++.
    - If WAIT_MAX≠0 and wait reaches WAIT_MAX, go to ERR.
    - Otherwise stay in REQ.
  - The wait counter resets on every entry to REQ.
- CAP (read only): mdr_re=1 for exactly one cycle. Go to DONE if k=N-1, else go to SHF.
- SHF: mdr_shift=1 for exactly one cycle, k++, go to REQ.
- DONE: done=1 and busy=1 for one cycle, then IDLE.
- ERR: err=1 and busy=1 for one cycle, then IDLE. No mdr_re/mdr_shift follows the failing byte.
- Latency from the accepting edge with mem_rdy=1 on first sight:
  - Read: done is high in cycle 3N.
  - Write: done is high in cycle 2N.
  - Each not-ready cycle adds one cycle.
- Strobe exclusivity: mdr_re, mdr_shift and mdr_we are never high together. mdr_shift never follows the final byte.
- N=1: no SHF state is ever visited.
- req behaviour:
  - req high while busy is ignored and not queued.
  - req held high through DONE starts the next transaction at the edge leaving the following IDLE cycle.
  - Inputs other than mem_rdy are ignored outside IDLE.

Decomposition:
- Shared package mdr_ctrl_pkg holds:
  - the state enum (IDLE, REQ, CAP, SHF, DONE, ERR);
  - RW_READ=0 and RW_WRITE=1;
  - defaults for BYTES_PER_WORD and ADDR_W, reused by the CPU control unit.
- One sub-module is natural: mdr_wait_timer, the WAIT_MAX counter with clear, enable and expired outputs.
- The byte index and address adder stay inline.

Test Plan:
- Read, N=2, base 0x0FE, mem_rdy tied 1, accept at edge 0:
  - mem_addr is 0x0FE in cycle 1 and 0x0FF in cycle 4.
  - mdr_re is high in cycles 2 and 5; mdr_shift is high in cycle 3.
  - done is high in cycle 6, then busy=0.
- Write, base 0x010, mem_rdy high only on the 3rd REQ cycle of each byte:
  - mem_en, mem_wr and mdr_we are high in cycles 1–3 and 5–7; mdr_shift is high in cycle 4.
  - done is high in cycle 8; mdr_re stays 0 throughout.
- Address wrap: read at base 0xFFF gives mem_addr 0xFFF then 0x000; done is reached normally.
- Timeout, WAIT_MAX=15, mem_rdy=0:
  - REQ is held for cycles 1–15 and err pulses in cycle 16.
  - done, mdr_re and mdr_shift all stay 0.
  - A fresh req is then accepted and completes.
- Busy handling:
  - A req pulse in cycle 2 of an active read is ignored; exactly one done results.
  - req held high throughout gives back-to-back transactions, with done in cycle 6 and the next done in cycle 13.
- Reset in a CAP cycle: at the next edge every output is 0 and the state is IDLE. No done or err appears for the aborted transfer.
